// File: rtl/gw_ahb_pkg.sv
// gw_ahb_pkg: shared AHB-Lite encodings and FSM state type for AHB initiators.
//   HTRANS / HRESP / HSIZE encodings, initiator state enum, request legality helper.
package gw_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] HRESP_RETRY = 2'b10;
  localparam logic [1:0] HRESP_SPLIT = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP2
  } state_t;

  // A request is legal when its size is byte/half/word and the address is
  // naturally aligned to that size.
  function automatic logic req_legal(input logic [2:0] size, input logic [1:0] addr);
    case (size)
      HSIZE_BYTE: req_legal = 1'b1;
      HSIZE_HALF: req_legal = ~addr[0];
      HSIZE_WORD: req_legal = (addr == 2'b00);
      default:    req_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/gw_ahb_rdata_align.sv
// gw_ahb_rdata_align: right-justifies and zero-extends AHB read data.
//   hrdata : raw 32-bit HRDATA
//   addr   : transfer address bits [1:0] (byte lane offset)
//   size   : HSIZE of the transfer
//   rdata  : HRDATA >> (8*addr), masked to 8/16 bits for byte/half transfers
module gw_ahb_rdata_align
  import gw_ahb_pkg::*;
(
  input  logic [31:0] hrdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  size,
  output logic [31:0] rdata
);

  logic [31:0] shifted;

  always_comb begin
    shifted = hrdata >> {addr, 3'b000};
    case (size)
      HSIZE_BYTE: rdata = {24'h000000, shifted[7:0]};
      HSIZE_HALF: rdata = {16'h0000, shifted[15:0]};
      default:    rdata = shifted;
    endcase
  end

endmodule

// File: rtl/gw_ahb_cmd_master.sv
// gw_ahb_cmd_master: single-outstanding AHB initiator driven by fabric commands.
//   req_*  : command handshake (valid/ready), write flag, address, size, lane-placed wdata
//   rsp_*  : one-cycle completion pulse with error flag and aligned read data
//   AHB_*  : AHB-Lite master port; SINGLE bursts, NONSEQ/IDLE only, RETRY/SPLIT re-issued
//            up to MAX_RETRY times before completing with an error.
module gw_ahb_cmd_master
  import gw_ahb_pkg::*;
#(
  parameter int unsigned MAX_RETRY = 3,
  parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
  input  logic        AHB_HCLK,
  input  logic        AHB_HRESETn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  AHB_HTRANS,
  output logic [2:0]  AHB_HBURST,
  output logic [3:0]  AHB_HPROT,
  output logic [2:0]  AHB_HSIZE,
  output logic        AHB_HWRITE,
  output logic [31:0] AHB_HADDR,
  output logic [31:0] AHB_HWDATA,
  input  logic [31:0] AHB_HRDATA,
  input  logic        AHB_HREADY,
  input  logic [1:0]  AHB_HRESP
);

  localparam int unsigned RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

  state_t        state, state_nx;
  logic [RW-1:0] retry_cnt, retry_nx;
  logic [31:0]   wdata_q, wdata_nx;
  logic [1:0]    htrans_nx;
  logic [31:0]   haddr_nx, hwdata_nx, rsp_rdata_nx, rdata_aligned;
  logic [2:0]    hsize_nx;
  logic          hwrite_nx, rsp_valid_nx, rsp_err_nx;
  logic          done, err;

  assign AHB_HBURST = 3'b000;
  assign AHB_HPROT  = HPROT_VAL;
  assign req_ready  = (state == ST_IDLE);

  // Latched HADDR/HSIZE describe the transfer in flight, so they drive alignment.
  gw_ahb_rdata_align u_align (
    .hrdata (AHB_HRDATA),
    .addr   (AHB_HADDR[1:0]),
    .size   (AHB_HSIZE),
    .rdata  (rdata_aligned)
  );

  always_comb begin
    state_nx     = state;
    retry_nx     = retry_cnt;
    wdata_nx     = wdata_q;
    htrans_nx    = AHB_HTRANS;
    haddr_nx     = AHB_HADDR;
    hwrite_nx    = AHB_HWRITE;
    hsize_nx     = AHB_HSIZE;
    hwdata_nx    = AHB_HWDATA;
    rsp_valid_nx = 1'b0;
    rsp_err_nx   = 1'b0;
    rsp_rdata_nx = rsp_rdata;
    done         = 1'b0;
    err          = 1'b0;

    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          retry_nx = '0;
          if (!req_legal(req_size, req_addr[1:0])) begin
            done = 1'b1;
            err  = 1'b1;
          end else begin
            state_nx  = ST_ADDR;
            htrans_nx = HTRANS_NONSEQ;
            haddr_nx  = req_addr;
            hwrite_nx = req_write;
            hsize_nx  = req_size;
            wdata_nx  = req_wdata;
          end
        end
      end
      ST_ADDR: begin
        if (AHB_HREADY) begin
          state_nx  = ST_DATA;
          htrans_nx = HTRANS_IDLE;
          hwdata_nx = wdata_q;
        end
      end
      ST_DATA: begin
        if (AHB_HREADY) begin
          // A non-OKAY response with HREADY high skips the first response
          // cycle; it is reported as a failed transfer.
          done = 1'b1;
          err  = (AHB_HRESP != HRESP_OKAY);
        end else if (AHB_HRESP != HRESP_OKAY) begin
          state_nx = ST_RESP2;
        end
      end
      ST_RESP2: begin
        if (AHB_HREADY) begin
          if ((AHB_HRESP == HRESP_RETRY || AHB_HRESP == HRESP_SPLIT) &&
              (retry_cnt < RETRY_LIMIT)) begin
            retry_nx  = retry_cnt + RW'(1);
            state_nx  = ST_ADDR;
            htrans_nx = HTRANS_NONSEQ;
          end else begin
            done = 1'b1;
            err  = 1'b1;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase

    if (done) begin
      state_nx     = ST_IDLE;
      rsp_valid_nx = 1'b1;
      rsp_err_nx   = err;
      rsp_rdata_nx = (err || AHB_HWRITE) ? '0 : rdata_aligned;
    end
  end

  always_ff @(posedge AHB_HCLK or negedge AHB_HRESETn) begin
    if (!AHB_HRESETn) begin
      state      <= ST_IDLE;
      retry_cnt  <= '0;
      wdata_q    <= '0;
      AHB_HTRANS <= HTRANS_IDLE;
      AHB_HADDR  <= '0;
      AHB_HWRITE <= 1'b0;
      AHB_HSIZE  <= HSIZE_WORD;
      AHB_HWDATA <= '0;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_rdata  <= '0;
    end else begin
      state      <= state_nx;
      retry_cnt  <= retry_nx;
      wdata_q    <= wdata_nx;
      AHB_HTRANS <= htrans_nx;
      AHB_HADDR  <= haddr_nx;
      AHB_HWRITE <= hwrite_nx;
      AHB_HSIZE  <= hsize_nx;
      AHB_HWDATA <= hwdata_nx;
      rsp_valid  <= rsp_valid_nx;
      rsp_err    <= rsp_err_nx;
      rsp_rdata  <= rsp_rdata_nx;
    end
  end

endmodule

// File: tb/tb_gw_ahb_cmd_master.sv
// tb_gw_ahb_cmd_master: self-checking bench for gw_ahb_cmd_master.
//   The bench plays a scripted AHB slave; expected responses are queued when a
//   command is issued and compared when rsp_valid appears.
module tb_gw_ahb_cmd_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_size;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [1:0]  htrans, hresp;
  logic [2:0]  hburst, hsize;
  logic [3:0]  hprot;
  logic        hwrite, hready;
  logic [31:0] haddr, hwdata, hrdata;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned nonseq_cnt = 0;
  int unsigned base;

  always #5 clk = ~clk;

  gw_ahb_cmd_master #(
    .MAX_RETRY (3),
    .HPROT_VAL (4'b0011)
  ) dut (
    .AHB_HCLK    (clk),
    .AHB_HRESETn (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_size    (req_size),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_err     (rsp_err),
    .rsp_rdata   (rsp_rdata),
    .AHB_HTRANS  (htrans),
    .AHB_HBURST  (hburst),
    .AHB_HPROT   (hprot),
    .AHB_HSIZE   (hsize),
    .AHB_HWRITE  (hwrite),
    .AHB_HADDR   (haddr),
    .AHB_HWDATA  (hwdata),
    .AHB_HRDATA  (hrdata),
    .AHB_HREADY  (hready),
    .AHB_HRESP   (hresp)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rsp(input logic err, input logic [31:0] rdata);
    exp_t e;
    e.err   = err;
    e.rdata = rdata;
    sb.push_back(e);
  endtask

  // Presents a command in the current (idle) cycle; returns in the cycle after acceptance.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                       input logic [31:0] wdata);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_size  = size;
    req_wdata = wdata;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input int unsigned max_cycles);
    int unsigned n = 0;
    @(negedge clk);
    while (!rsp_valid && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(rsp_valid), 32'h1);
  endtask

  // Response scoreboard.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && rsp_valid) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 32'(rsp_valid), 32'h0);
      end else begin
        e = sb.pop_front();
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
        chk("rsp_rdata", rsp_rdata, e.rdata);
      end
    end
  end

  // Completed address phases (NONSEQ sampled with HREADY high).
  always @(posedge clk) begin
    if (rst_n && htrans == 2'b10 && hready) nonseq_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  logic [31:0] bad_addr [5] = '{32'h1, 32'h2, 32'h3, 32'h0, 32'h4};
  logic [2:0]  bad_size [5] = '{3'd2, 3'd2, 3'd1, 3'd3, 3'd7};

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_size = '0; req_wdata = '0;
    hrdata = '0; hready = 1'b1; hresp = 2'b00;

    // Reset values
    @(posedge clk); #1;
    chk("rst_htrans", 32'(htrans), 32'h0);
    chk("rst_haddr", haddr, 32'h0);
    chk("rst_hwrite", 32'(hwrite), 32'h0);
    chk("rst_hsize", 32'(hsize), 32'h2);
    chk("rst_hwdata", hwdata, 32'h0);
    chk("rst_hburst", 32'(hburst), 32'h0);
    chk("rst_hprot", 32'(hprot), 32'h3);
    chk("rst_req_ready", 32'(req_ready), 32'h1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Zero-wait word write
    expect_rsp(1'b0, 32'h0);
    issue(1'b1, 32'h8, 3'd2, 32'h1234);
    @(negedge clk);
    chk("wr_c1_htrans", 32'(htrans), 32'h2);
    chk("wr_c1_haddr", haddr, 32'h8);
    chk("wr_c1_hwrite", 32'(hwrite), 32'h1);
    chk("wr_c1_hsize", 32'(hsize), 32'h2);
    chk("wr_c1_ready", 32'(req_ready), 32'h0);
    tick(); @(negedge clk);
    chk("wr_c2_htrans", 32'(htrans), 32'h0);
    chk("wr_c2_hwdata", hwdata, 32'h1234);
    chk("wr_c2_rsp_valid", 32'(rsp_valid), 32'h0);
    tick(); @(negedge clk);
    chk("wr_c3_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("wr_c3_ready", 32'(req_ready), 32'h1);

    // Halfword read with two wait states
    tick();
    expect_rsp(1'b0, 32'h0000_BEEF);
    issue(1'b0, 32'hE, 3'd1, 32'h0);
    @(negedge clk);
    chk("rd_c1_htrans", 32'(htrans), 32'h2);
    chk("rd_c1_haddr", haddr, 32'hE);
    tick(); hready = 1'b0; @(negedge clk);
    chk("rd_c2_haddr", haddr, 32'hE);
    chk("rd_c2_htrans", 32'(htrans), 32'h0);
    tick(); hready = 1'b0; @(negedge clk);
    chk("rd_c3_haddr", haddr, 32'hE);
    chk("rd_c3_rsp_valid", 32'(rsp_valid), 32'h0);
    tick(); hready = 1'b1; hrdata = 32'hBEEF_0000; @(negedge clk);
    chk("rd_c4_haddr", haddr, 32'hE);
    chk("rd_c4_rsp_valid", 32'(rsp_valid), 32'h0);
    tick(); hrdata = 32'h0; @(negedge clk);
    chk("rd_c5_rsp_valid", 32'(rsp_valid), 32'h1);

    // Two-cycle ERROR, then back-to-back request in the response cycle
    tick();
    expect_rsp(1'b1, 32'h0);
    issue(1'b0, 32'h10, 3'd2, 32'h0);
    tick(); hready = 1'b0; hresp = 2'b01; hrdata = 32'hFFFF_FFFF;
    tick(); hready = 1'b1; hresp = 2'b01;
    @(negedge clk);
    chk("err_c3_rsp_valid", 32'(rsp_valid), 32'h0);
    tick(); hresp = 2'b00; hrdata = 32'h0;
    expect_rsp(1'b0, 32'h0);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_size = 3'd2; req_wdata = 32'hA5;
    @(negedge clk);
    chk("err_c4_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("err_c4_ready", 32'(req_ready), 32'h1);
    tick(); req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_htrans", 32'(htrans), 32'h2);
    chk("b2b_haddr", haddr, 32'h20);
    wait_rsp("b2b_rsp_seen", 8);

    // RETRY four times: three re-issues, then error
    tick();
    base = nonseq_cnt;
    expect_rsp(1'b1, 32'h0);
    issue(1'b0, 32'h40, 3'd2, 32'h0);
    for (int unsigned a = 0; a < 4; a++) begin
      hready = 1'b1; hresp = 2'b00;
      @(negedge clk);
      chk("retry4_nonseq", 32'(htrans), 32'h2);
      tick(); hready = 1'b0; hresp = 2'b10;
      tick(); hready = 1'b1; hresp = 2'b10;
      tick();
    end
    hresp = 2'b00;
    @(negedge clk);
    chk("retry4_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("retry4_addr_phases", nonseq_cnt - base, 32'd4);

    // RETRY twice, then OKAY
    tick();
    base = nonseq_cnt;
    expect_rsp(1'b0, 32'h1234_5678);
    issue(1'b0, 32'h44, 3'd2, 32'h0);
    for (int unsigned a = 0; a < 2; a++) begin
      hready = 1'b1; hresp = 2'b00;
      tick(); hready = 1'b0; hresp = 2'b10;
      tick(); hready = 1'b1; hresp = 2'b10;
      tick();
    end
    hready = 1'b1; hresp = 2'b00;
    @(negedge clk);
    chk("retry2_nonseq", 32'(htrans), 32'h2);
    tick(); hrdata = 32'h1234_5678;
    tick(); hrdata = 32'h0;
    @(negedge clk);
    chk("retry2_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("retry2_addr_phases", nonseq_cnt - base, 32'd3);

    // Illegal requests: no bus transfer, error one cycle after acceptance
    base = nonseq_cnt;
    for (int unsigned i = 0; i < 5; i++) begin
      tick();
      expect_rsp(1'b1, 32'h0);
      issue(1'b0, bad_addr[i], bad_size[i], 32'h0);
      @(negedge clk);
      chk("bad_htrans", 32'(htrans), 32'h0);
      chk("bad_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("bad_ready", 32'(req_ready), 32'h1);
    end
    chk("bad_addr_phases", nonseq_cnt - base, 32'd0);

    // Byte read from the top lane
    tick();
    expect_rsp(1'b0, 32'h0000_00AB);
    issue(1'b0, 32'h3, 3'd0, 32'h0);
    tick(); hrdata = 32'hAB00_0000;
    tick(); hrdata = 32'h0;
    @(negedge clk);
    chk("byte_rsp_valid", 32'(rsp_valid), 32'h1);

    // Reset asserted during the data phase
    tick();
    issue(1'b0, 32'h50, 3'd2, 32'h0);
    tick(); hready = 1'b0;
    #2; rst_n = 1'b0; #1;
    chk("arst_htrans", 32'(htrans), 32'h0);
    chk("arst_ready", 32'(req_ready), 32'h1);
    chk("arst_haddr", haddr, 32'h0);
    chk("arst_rsp_valid", 32'(rsp_valid), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1; hready = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("arst_no_rsp", 32'(rsp_valid), 32'h0);
    end
    tick();
    expect_rsp(1'b0, 32'hCAFE_F00D);
    issue(1'b0, 32'h54, 3'd2, 32'h0);
    hrdata = 32'hCAFE_F00D;
    wait_rsp("arst_fresh_rsp_seen", 8);

    repeat (3) tick();
    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
